spi_slave: RTL and testbench

SPI target that terminates the 24-bit command/address/data frames issued by the team's SPI master. It samples `cs`, `sck` and `mosi` in the system clock domain, decodes the frame, and either writes an internal bank of 8-bit registers or returns a register's contents on `miso`. A side port exposes the register bank and signals every completed write to the surrounding logic.

---
 rtl/spi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave                                                       |
// | Desc     : SPI target for 24-bit cmd/addr/data frames with an 8-bit        |
// |            register bank, write-commit side port and frame-abort flag.     |
// |            Define SPI_SLAVE_SYNC_EN to add 2-FF input synchronizers.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spi_slave #(
  parameter int REG_COUNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  input  logic [7:0] ext_sel,
  output logic [7:0] ext_rdata
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [4:0] LAST_CMD_BIT  = 5'd7;
  localparam logic [4:0] LAST_ADDR_BIT = 5'd15;
  localparam logic [4:0] FIRST_RD_BIT  = 5'd17;
  localparam logic [4:0] LAST_DATA_BIT = 5'd23;

  logic cs_in;
  logic sck_in;
  logic mosi_in;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] cs_sync;
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign cs_in   = cs_sync[1];
  assign sck_in  = sck_sync[1];
  assign mosi_in = mosi_sync[1];
`else
  assign cs_in   = cs;
  assign sck_in  = sck;
  assign mosi_in = mosi;
`endif

  // Single capture stage shared by both builds; sck_d holds the previous sample.
  logic cs_q;
  logic sck_q;
  logic sck_d;
  logic mosi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= 1'b1;
      sck_q  <= 1'b1;
      sck_d  <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      cs_q   <= cs_in;
      sck_q  <= sck_in;
      sck_d  <= sck_q;
      mosi_q <= mosi_in;
    end
  end

  logic rise;
  logic fall;

  assign rise = sck_q & ~sck_d;
  assign fall = ~sck_q & sck_d;

  logic [2:0] state;
  logic [4:0] cnt;
  logic [7:0] rx;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic [6:0] tx_rem;
  logic [7:0] rx_next;
  logic       commit;

  assign rx_next = {rx[6:0], mosi_q};
  assign commit  = (state == ST_DATA) && !cs_q && rise &&
                   (cnt == LAST_DATA_BIT) && (cmd == 8'h00);

  // Full 256-entry view so any 8-bit address decodes; unimplemented slots read 0.
  logic [7:0] bank [256];

  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_bank
      if (gi < REG_COUNT) begin : g_reg
        logic [7:0] q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            q <= 8'h00;
          end else if (commit && (addr == 8'(gi))) begin
            q <= rx_next;
          end
        end
        assign bank[gi] = q;
      end else begin : g_empty
        assign bank[gi] = 8'h00;
      end
    end
  endgenerate

  assign ext_rdata = bank[ext_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      rx        <= 8'h00;
      cmd       <= 8'h00;
      addr      <= 8'h00;
      tx_rem    <= 7'h00;
      miso      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (!cs_q) begin
            state <= ST_CMD;
            cnt   <= 5'd0;
            rx    <= 8'h00;
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          if (cs_q) begin
            // Abort takes priority over any edge seen in the same cycle.
            state     <= ST_IDLE;
            frame_err <= 1'b1;
            cnt       <= 5'd0;
            rx        <= 8'h00;
            cmd       <= 8'h00;
            addr      <= 8'h00;
            tx_rem    <= 7'h00;
            miso      <= 1'b0;
          end else if (rise) begin
            rx  <= rx_next;
            cnt <= cnt + 5'd1;
            case (state)
              ST_CMD: begin
                if (cnt == LAST_CMD_BIT) begin
                  cmd   <= rx_next;
                  state <= ST_ADDR;
                end
              end
              ST_ADDR: begin
                if (cnt == LAST_ADDR_BIT) begin
                  addr  <= rx_next;
                  state <= ST_DATA;
                  if (cmd != 8'h00) begin
                    miso   <= bank[rx_next][7];
                    tx_rem <= bank[rx_next][6:0];
                  end
                end
              end
              ST_DATA: begin
                if (cnt == LAST_DATA_BIT) begin
                  state <= ST_DONE;
                  miso  <= 1'b0;
                  if (cmd == 8'h00) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= addr;
                    wr_data  <= rx_next;
                  end
                end
              end
              default: ;
            endcase
          end else if (fall && (state == ST_DATA) && (cmd != 8'h00) &&
                       (cnt >= FIRST_RD_BIT)) begin
            // The fall right after the 16th rise keeps bit 7 for the 17th rise.
            miso   <= tx_rem[6];
            tx_rem <= {tx_rem[5:0], 1'b0};
          end
        end
        ST_DONE: begin
          miso <= 1'b0;
          if (cs_q) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
          end
        end
        default: begin
          state <= ST_IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_slave                                                    |
// | Desc     : Randomized scoreboard bench for spi_slave with a frame-level    |
// |            register model. Revision : 1.0                                  |
// +----------------------------------------------------------------------------+
module tb_spi_slave;

  localparam int REGS = 16;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] ext_sel;
  logic [7:0] ext_rdata;

  spi_slave #(.REG_COUNT(REGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .ext_sel   (ext_sel),
    .ext_rdata (ext_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [256];
  logic [15:0] exp_wr[$];
  logic        exp_ferr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  got_rd[$];
  logic [7:0]  exp_ext[$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin : monitor
    int cs_hi_cnt;
    logic [15:0] e;
    cs_hi_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_valid) begin
        if (exp_wr.size() == 0) chk("wr_valid_unexpected", {31'd0, wr_valid}, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
        end
      end
      if (frame_err) begin
        if (exp_ferr.size() == 0) chk("frame_err_unexpected", {31'd0, frame_err}, 32'd0);
        else void'(exp_ferr.pop_front());
      end
      if (got_rd.size() > 0 && exp_rd.size() > 0)
        chk("miso_byte", {24'd0, got_rd.pop_front()}, {24'd0, exp_rd.pop_front()});
      if (exp_ext.size() > 0)
        chk("ext_rdata", {24'd0, ext_rdata}, {24'd0, exp_ext.pop_front()});
      cs_hi_cnt = cs ? cs_hi_cnt + 1 : 0;
      if (cs_hi_cnt == 8) chk("miso_idle_zero", {31'd0, miso}, 32'd0);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic start_frame();
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    sck = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic m);
    sck = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    m = miso;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input int nbits);
    logic [23:0] w;
    logic [7:0]  rd;
    logic        m;
    w  = {c, a, d};
    rd = 8'h00;
    if (nbits < 24) exp_ferr.push_back(1'b1);
    else if (c == 8'h00) begin
      exp_wr.push_back({a, d});
      if (int'(a) < REGS) model[a] = d;
    end else exp_rd.push_back(model[a]);
    start_frame();
    for (int i = 0; i < nbits; i++) begin
      clock_bit((i < 24) ? w[23 - i] : 1'($urandom), m);
      if (i >= 16 && i < 24) rd = {rd[6:0], m};
    end
    end_frame();
    if (nbits >= 24 && c != 8'h00) got_rd.push_back(rd);
  endtask

  task automatic ext_check(input logic [7:0] sel);
    @(negedge clk);
    ext_sel = sel;
    exp_ext.push_back(model[sel]);
    @(negedge clk);
  endtask

  initial begin : stimulus
    logic [7:0] c, a, d;
    int nb;
    logic m;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b0; cs = 1'b1; sck = 1'b1; mosi = 1'b0; ext_sel = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ext_check(8'd7);

    frame(8'h00, 8'h05, 8'hA7, 24);
    ext_check(8'd5);
    frame(8'h00, 8'h03, 8'h3C, 24);
    frame(8'h01, 8'h03, 8'h00, 24);
    frame(8'h01, 8'h40, 8'h00, 24);
    frame(8'h00, 8'h40, 8'h99, 24);
    for (int i = 0; i < REGS; i++) ext_check(8'(i));
    ext_check(8'h40);
    frame(8'h00, 8'h02, 8'h55, 12);
    ext_check(8'd2);
    frame(8'h00, 8'h02, 8'h66, 24);
    ext_check(8'd2);
    frame(8'h00, 8'h09, 8'hC3, 30);
    frame(8'h80, 8'h09, 8'h00, 30);

    for (int n = 0; n < 40; n++) begin
      c  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, REGS - 1));
      d  = 8'($urandom);
      nb = $urandom_range(0, 9);
      nb = (nb == 0) ? $urandom_range(1, 23) : (nb == 1) ? $urandom_range(25, 30) : 24;
      frame(c, a, d, nb);
      if (n % 4 == 0) ext_check(8'($urandom_range(0, 31)));
    end

    // Reset in the middle of a read of a nonzero register.
    frame(8'h00, 8'h06, 8'hFF, 24);
    start_frame();
    for (int i = 0; i < 20; i++) clock_bit(((24'h010600 >> (23 - i)) & 24'd1) != 0, m);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_miso", {31'd0, miso}, 32'd0);
    cs = 1'b1; sck = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (4) @(negedge clk);
    for (int i = 0; i < REGS; i++) ext_check(8'(i));
    frame(8'h00, 8'h0A, 8'h5A, 24);
    frame(8'h02, 8'h0A, 8'h00, 24);

    repeat (20) @(negedge clk);
    chk("pending_wr", exp_wr.size(), 32'd0);
    chk("pending_ferr", exp_ferr.size(), 32'd0);
    chk("pending_rd", exp_rd.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
